// File: rtl/toy_pack.sv
// Shared MSHR sizing constants and the entry index type.
package toy_pack;

    localparam int MSHR_ENTRY_NUM = 8;

    typedef logic [$clog2(MSHR_ENTRY_NUM)-1:0] mshr_idx_t;

endpackage

// File: rtl/cmn_lead_one.sv
// Lowest-set-bit finder: isolates the least significant 1 of vec and
// reports it as a one-hot mask, a binary index and a valid flag.
module cmn_lead_one #(
    parameter int WIDTH = 8,
    parameter int BIN_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic [BIN_W-1:0] bin,
    output logic             vld
);

    localparam logic [WIDTH-1:0] ONE = 1;

    // Two's-complement trick keeps only the lowest set bit.
    assign onehot = vec & (~vec + ONE);
    assign vld    = |vec;

    // Encode the one-hot mask; bits are mutually exclusive so OR-ing is exact.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | BIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/mshr_idx_pool.sv
// MSHR index pool: tracks each entry as FREE / RSVD / BUSY, keeps a small
// FIFO of pre-reserved free indices ready for the consumer, and validates
// releases coming back from BUSY entries.
module mshr_idx_pool
    import toy_pack::*;
#(
    parameter int ENTRY_NUM   = MSHR_ENTRY_NUM,
    parameter int BUF_DEPTH   = 2,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   alloc_vld,
    input  logic                   alloc_rdy,
    output logic [INDEX_WIDTH-1:0] alloc_idx,
    input  logic                   rel_vld,
    input  logic [INDEX_WIDTH-1:0] rel_idx,
    output logic                   rel_err,
    output logic [ENTRY_NUM-1:0]   busy_vec,
    output logic [INDEX_WIDTH:0]   free_cnt
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [ENTRY_NUM-1:0] ENTRY_ONE = 1;
    localparam logic [INDEX_WIDTH:0] FCNT_ONE  = 1;
    localparam logic [INDEX_WIDTH:0] FCNT_INIT = (INDEX_WIDTH+1)'(ENTRY_NUM);
    localparam logic [CNT_W-1:0]     OCC_ONE   = 1;
    localparam logic [CNT_W-1:0]     OCC_FULL  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_ONE   = 1;
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(BUF_DEPTH - 1);

    // Entry state: RSVD is implied by neither FREE nor BUSY.
    logic [ENTRY_NUM-1:0]   free_reg;
    logic [ENTRY_NUM-1:0]   busy_reg;
    logic [ENTRY_NUM-1:0]   free_next;
    logic [ENTRY_NUM-1:0]   busy_next;

    // Reservation buffer.
    logic [INDEX_WIDTH-1:0] buf_reg [BUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       occ_reg;
    logic [CNT_W-1:0]       occ_next;

    logic [INDEX_WIDTH:0]   free_cnt_reg;
    logic [INDEX_WIDTH:0]   free_cnt_next;
    logic                   rel_err_reg;

    logic [ENTRY_NUM-1:0]   sel_onehot;
    logic [INDEX_WIDTH-1:0] sel_idx;
    logic                   sel_vld;

    logic                   push;
    logic                   pop;
    logic                   rel_in_range;
    logic                   rel_ok;
    logic [INDEX_WIDTH-1:0] head_idx;
    logic [ENTRY_NUM-1:0]   push_oh;
    logic [ENTRY_NUM-1:0]   pop_oh;
    logic [ENTRY_NUM-1:0]   rel_oh;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    cmn_lead_one #(
        .WIDTH (ENTRY_NUM),
        .BIN_W (INDEX_WIDTH)
    ) u_lead_one (
        .vec    (free_reg),
        .onehot (sel_onehot),
        .bin    (sel_idx),
        .vld    (sel_vld)
    );

    // Out-of-range check only exists when the index field can exceed the entry count.
    generate
        if ((1 << INDEX_WIDTH) > ENTRY_NUM) begin : g_range
            assign rel_in_range = ({1'b0, rel_idx} < FCNT_INIT);
        end else begin : g_norange
            assign rel_in_range = 1'b1;
        end
    endgenerate

    assign head_idx = buf_reg[rd_ptr_reg];

    // Push looks only at registered occupancy, so a same-cycle pop never frees room early.
    assign push   = (occ_reg != OCC_FULL) && sel_vld;
    assign pop    = (occ_reg != '0) && alloc_rdy;
    assign rel_ok = rel_vld && rel_in_range && busy_reg[rel_idx];

    assign push_oh = push   ? sel_onehot            : '0;
    assign pop_oh  = pop    ? (ENTRY_ONE << head_idx) : '0;
    assign rel_oh  = rel_ok ? (ENTRY_ONE << rel_idx)  : '0;

    // Pushed entry was FREE, popped entry RSVD, released entry BUSY: all distinct.
    assign free_next = (free_reg & ~push_oh) | rel_oh;
    assign busy_next = (busy_reg & ~rel_oh) | pop_oh;

    // Next occupancy and free count from the push/pop/release events.
    always_comb begin
        occ_next      = occ_reg;
        free_cnt_next = free_cnt_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_ONE;
            2'b01:   occ_next = occ_reg - OCC_ONE;
            default: occ_next = occ_reg;
        endcase
        case ({rel_ok, push})
            2'b10:   free_cnt_next = free_cnt_reg + FCNT_ONE;
            2'b01:   free_cnt_next = free_cnt_reg - FCNT_ONE;
            default: free_cnt_next = free_cnt_reg;
        endcase
    end

    // Per-entry FREE/BUSY flags.
    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
            // Entry state register; reset returns every entry to FREE.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    free_reg[gi] <= 1'b1;
                    busy_reg[gi] <= 1'b0;
                end else begin
                    free_reg[gi] <= free_next[gi];
                    busy_reg[gi] <= busy_next[gi];
                end
            end
        end
    endgenerate

    // Buffer slots.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            // Capture the selected free index into the slot under the write pointer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    buf_reg[gi] <= sel_idx;
                end
            end
        end
    endgenerate

    // Buffer pointers, occupancy, free count and release-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            free_cnt_reg <= FCNT_INIT;
            rel_err_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            occ_reg      <= occ_next;
            free_cnt_reg <= free_cnt_next;
            rel_err_reg  <= rel_vld && !rel_ok;
        end
    end

    assign alloc_vld = (occ_reg != '0);
    assign alloc_idx = head_idx;
    assign rel_err   = rel_err_reg;
    assign busy_vec  = busy_reg;
    assign free_cnt  = free_cnt_reg;

endmodule
